// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: size codes, fsm states and request legality check shared by the lsu
package lsu_mem_ctrl_pkg;
  localparam logic [2:0] MEM_BYTE = 3'b000;
  localparam logic [2:0] MEM_HALF = 3'b001;
  localparam logic [2:0] MEM_WORD = 3'b010;
  localparam logic [2:0] MEM_BU   = 3'b100;
  localparam logic [2:0] MEM_HU   = 3'b101;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic logic req_bad(input logic we, input logic [2:0] size, input logic [1:0] off);
    return size == 3'b011 || size[2:1] == 2'b11 || (we && size[2]) ||
           (size[1:0] == 2'b01 && off[0]) || (size == MEM_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: request, response and ram signals of the load/store unit
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_size;
  logic [4:0]        req_rd;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [4:0]        rsp_rd;
  logic              rsp_we;
  logic              rsp_err;
  logic              mem_start;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_load;
  logic [31:0]       mem_in;
  logic [2:0]        mem_siz;
  logic [31:0]       mem_out;
  logic              mem_busy;
  logic              mem_done;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_rd, rsp_ready,
           mem_out, mem_busy, mem_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_we, rsp_err,
           mem_start, mem_adr, mem_load, mem_in, mem_siz
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_rd, rsp_ready,
           mem_out, mem_busy, mem_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_we, rsp_err,
           mem_start, mem_adr, mem_load, mem_in, mem_siz
  );
endinterface

// File: rtl/lsu_mem_ctrl_load_extend.sv
// lsu_mem_ctrl_load_extend: selects the addressed lane of a ram word and sign/zero-extends it
module lsu_mem_ctrl_load_extend
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  output logic [31:0] ext
);
  logic [31:0] lane;
  always_comb begin
    lane = data >> {off, 3'b000};
    ext = size == MEM_BYTE ? {{24{lane[7]}}, lane[7:0]} :
          size == MEM_BU   ? {24'd0, lane[7:0]} :
          size == MEM_HALF ? {{16{lane[15]}}, lane[15:0]} :
          size == MEM_HU   ? {16'd0, lane[15:0]} : data;
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit bridging EX requests to the ram start/busy/done protocol
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst_n,
  lsu_mem_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  state_t            state, nxt;
  logic [CW-1:0]     cnt;
  logic [1:0]        off;
  logic [2:0]        size;
  logic [31:0]       ext;
  logic              acc, bad, hit, tmo;
  logic              rsp_valid, rsp_we, rsp_err, mem_start, mem_load;
  logic [31:0]       rsp_rdata, mem_in;
  logic [4:0]        rsp_rd;
  logic [ADDR_W-1:0] mem_adr;
  logic [2:0]        mem_siz;
  assign acc = bus.req_valid && state == IDLE;
  assign bad = req_bad(bus.req_we, bus.req_size, bus.req_addr[1:0]);
  assign hit = cnt != '0 && bus.mem_done && !bus.mem_busy;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_rd    = rsp_rd;
  assign bus.rsp_we    = rsp_we;
  assign bus.rsp_err   = rsp_err;
  assign bus.mem_start = mem_start;
  assign bus.mem_adr   = mem_adr;
  assign bus.mem_load  = mem_load;
  assign bus.mem_in    = mem_in;
  assign bus.mem_siz   = mem_siz;
  lsu_mem_ctrl_load_extend u_ext (
    .data (bus.mem_out),
    .off  (off),
    .size (size),
    .ext  (ext)
  );
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (acc ? (bad ? RESP : ISSUE) : IDLE) :
          state == ISSUE ? WAIT :
          state == WAIT  ? (hit || tmo ? RESP : WAIT) :
          (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      rsp_rd    <= '0;
      mem_start <= 1'b0;
      mem_load  <= 1'b0;
      mem_adr   <= '0;
      mem_in    <= '0;
      mem_siz   <= MEM_WORD;
      cnt       <= '0;
      off       <= '0;
      size      <= '0;
    end else begin
      mem_start <= state == ISSUE;
      if (acc) begin
        rsp_rd    <= bus.req_rd;
        rsp_we    <= bus.req_we;
        rsp_rdata <= '0;
        rsp_err   <= bad;
        rsp_valid <= bad;
        off       <= bus.req_addr[1:0];
        size      <= bus.req_size;
        if (!bad) begin
          mem_adr  <= bus.req_we ? bus.req_addr : {bus.req_addr[ADDR_W-1:2], 2'b00};
          mem_siz  <= bus.req_we ? bus.req_size : MEM_WORD;
          mem_load <= bus.req_we;
          if (bus.req_we) mem_in <= bus.req_wdata;
        end
      end
      if (state == WAIT) begin
        cnt <= hit || tmo ? '0 : cnt + 1'b1;
        if (hit || tmo) rsp_valid <= 1'b1;
        if (hit && !rsp_we) rsp_rdata <= ext;
        if (!hit && tmo) rsp_err <= 1'b1;
      end
      if (state == RESP && bus.rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of the load/store unit against a small ram model
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic preload = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int starts = 0;
  logic [7:0] ram [0:255];
  logic [7:0] a;
  lsu_mem_ctrl_if bus ();
  lsu_mem_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  assign a = bus.mem_adr[7:0];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_start) starts <= starts + 1;
    if (preload) begin
      ram[8'h10] <= 8'h80;
      ram[8'h11] <= 8'h7F;
      ram[8'h12] <= 8'h34;
      ram[8'h13] <= 8'h12;
      ram[8'h20] <= 8'h11;
      ram[8'h21] <= 8'h22;
      ram[8'h22] <= 8'h33;
      ram[8'h23] <= 8'h44;
      bus.mem_busy <= 1'b0;
      bus.mem_done <= 1'b1;
      bus.mem_out <= 32'd0;
    end else if (bus.mem_start) begin
      bus.mem_busy <= stall;
      bus.mem_done <= !stall;
      if (!stall && bus.mem_load) begin
        ram[a] <= bus.mem_in[7:0];
        if (bus.mem_siz != MEM_BYTE) ram[a + 8'd1] <= bus.mem_in[15:8];
        if (bus.mem_siz == MEM_WORD) begin
          ram[a + 8'd2] <= bus.mem_in[23:16];
          ram[a + 8'd3] <= bus.mem_in[31:24];
        end
      end else if (!stall) begin
        bus.mem_out <= {ram[a + 8'd3], ram[a + 8'd2], ram[a + 8'd1], ram[a]};
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_size = size;
    bus.req_rd = rd;
    tick;
    bus.req_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    preload = 1'b1;
    tick;
    preload = 1'b0;
    tick;
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_we, bus.mem_start, bus.mem_load} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags got %b expected 100000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_we, bus.mem_start, bus.mem_load});
    end
    vectors++;
    if ({bus.rsp_rdata, bus.rsp_rd, bus.mem_adr, bus.mem_in, bus.mem_siz} !== {32'd0, 5'd0, 32'd0, 32'd0, MEM_WORD}) begin
      miscompares++;
      $display("FAIL reset_data got rdata=%h rd=%h adr=%h in=%h siz=%h", bus.rsp_rdata, bus.rsp_rd,
               bus.mem_adr, bus.mem_in, bus.mem_siz);
    end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_load(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] exp,
                           input logic [4:0] rd);
    int s0;
    s0 = starts;
    send(1'b0, addr, 32'd0, size, rd);
    tick;
    vectors++;
    if ({bus.mem_start, bus.mem_load, bus.mem_siz, bus.mem_adr} !== {1'b1, 1'b0, MEM_WORD, addr & ~32'd3}) begin
      miscompares++;
      $display("FAIL load_issue addr=%h got start=%b load=%b siz=%h adr=%h expected 1 0 %h %h", addr,
               bus.mem_start, bus.mem_load, bus.mem_siz, bus.mem_adr, MEM_WORD, addr & ~32'd3);
    end
    tick;
    vectors++;
    if ({bus.mem_start, bus.rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL load_wait addr=%h got start=%b rsp_valid=%b expected 0 0", addr, bus.mem_start, bus.rsp_valid);
    end
    tick;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_we, bus.rsp_rd, bus.rsp_rdata} !== {3'b100, rd, exp}) begin
      miscompares++;
      $display("FAIL load_rsp addr=%h size=%b got v=%b err=%b we=%b rd=%0d data=%h expected 1 0 0 %0d %h", addr,
               size, bus.rsp_valid, bus.rsp_err, bus.rsp_we, bus.rsp_rd, bus.rsp_rdata, rd, exp);
    end
    tick;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || starts - s0 != 1) begin
      miscompares++;
      $display("FAIL load_done addr=%h got rsp_valid=%b req_ready=%b pulses=%0d expected 0 1 1", addr,
               bus.rsp_valid, bus.req_ready, starts - s0);
    end
  endtask
  task automatic test_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size,
                            input logic [4:0] rd);
    send(1'b1, addr, wdata, size, rd);
    tick;
    vectors++;
    if ({bus.mem_start, bus.mem_load, bus.mem_siz, bus.mem_adr, bus.mem_in} !== {2'b11, size, addr, wdata}) begin
      miscompares++;
      $display("FAIL store_issue got start=%b load=%b siz=%h adr=%h in=%h expected 1 1 %h %h %h", bus.mem_start,
               bus.mem_load, bus.mem_siz, bus.mem_adr, bus.mem_in, size, addr, wdata);
    end
    tick;
    tick;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_we, bus.rsp_rd, bus.rsp_rdata} !== {3'b101, rd, 32'd0}) begin
      miscompares++;
      $display("FAIL store_rsp got v=%b err=%b we=%b rd=%0d data=%h expected 1 0 1 %0d 0", bus.rsp_valid,
               bus.rsp_err, bus.rsp_we, bus.rsp_rd, bus.rsp_rdata, rd);
    end
    tick;
  endtask
  task automatic test_stores;
    int s0;
    s0 = starts;
    test_store(32'h21, 32'hAABBCCDD, MEM_BYTE, 5'd7);
    vectors++;
    if ({ram[8'h20], ram[8'h21], ram[8'h22]} !== 24'h11DD33 || starts - s0 != 1) begin
      miscompares++;
      $display("FAIL store_byte_ram got %h %h %h pulses=%0d expected 11 dd 33 1", ram[8'h20], ram[8'h21],
               ram[8'h22], starts - s0);
    end
    test_store(32'h22, 32'h00005566, MEM_HALF, 5'd8);
    test_load(32'h20, MEM_WORD, 32'h5566DD11, 5'd9);
  endtask
  task automatic err_case(input logic we, input logic [31:0] addr, input logic [2:0] size);
    int s0;
    s0 = starts;
    send(we, addr, 32'h12345678, size, 5'd3);
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_start} !== {2'b11, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL err_rsp we=%b addr=%h size=%b got v=%b err=%b data=%h start=%b expected 1 1 0 0", we, addr,
               size, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.mem_start);
    end
    tick;
    tick;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || starts != s0) begin
      miscompares++;
      $display("FAIL err_done addr=%h got rsp_valid=%b req_ready=%b pulses=%0d expected 0 1 0", addr,
               bus.rsp_valid, bus.req_ready, starts - s0);
    end
  endtask
  task automatic test_errors;
    err_case(1'b0, 32'h12, MEM_WORD);
    err_case(1'b0, 32'h13, MEM_HALF);
    err_case(1'b0, 32'h11, MEM_HU);
    err_case(1'b0, 32'h10, 3'b011);
    err_case(1'b0, 32'h10, 3'b111);
    err_case(1'b1, 32'h10, MEM_BU);
  endtask
  task automatic test_timeout;
    stall = 1'b1;
    send(1'b0, 32'h10, 32'd0, MEM_WORD, 5'd5);
    repeat (16) tick;
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early got rsp_valid=%b expected 0", bus.rsp_valid);
    end
    tick;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b11, 32'd0}) begin
      miscompares++;
      $display("FAIL timeout_rsp got v=%b err=%b data=%h expected 1 1 0", bus.rsp_valid, bus.rsp_err,
               bus.rsp_rdata);
    end
    tick;
    stall = 1'b0;
  endtask
  task automatic test_backpressure;
    int s0;
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'h13, 32'd0, MEM_BU, 5'd9);
    repeat (3) tick;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rd, bus.rsp_rdata} !== {2'b10, 5'd9, 32'h12}) begin
      miscompares++;
      $display("FAIL bp_rsp got v=%b err=%b rd=%0d data=%h expected 1 0 9 00000012", bus.rsp_valid, bus.rsp_err,
               bus.rsp_rd, bus.rsp_rdata);
    end
    s0 = starts;
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h10;
    bus.req_size = MEM_WORD;
    bus.req_we = 1'b0;
    bus.req_rd = 5'd1;
    for (int i = 0; i < 5; i++) begin
      tick;
      vectors++;
      if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_rdata, bus.req_ready, bus.mem_start} !== {1'b1, 5'd9, 32'h12, 2'b00}) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got v=%b rd=%0d data=%h req_ready=%b start=%b expected 1 9 00000012 0 0",
                 i, bus.rsp_valid, bus.rsp_rd, bus.rsp_rdata, bus.req_ready, bus.mem_start);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || starts != s0) begin
      miscompares++;
      $display("FAIL bp_release got rsp_valid=%b req_ready=%b pulses=%0d expected 0 1 0", bus.rsp_valid,
               bus.req_ready, starts - s0);
    end
    test_load(32'h10, MEM_HALF, 32'h00007F80, 5'd10);
  endtask
  task automatic test_back_to_back;
    int p, last, gap, nrsp, acc;
    p = 0;
    last = 0;
    gap = 0;
    nrsp = 0;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 32'h10;
    bus.req_size = MEM_WORD;
    bus.req_rd = 5'd4;
    for (int i = 0; i < 14; i++) begin
      if (bus.req_ready && bus.req_valid) acc++;
      tick;
      if (acc == 2) bus.req_valid = 1'b0;
      if (bus.mem_start) begin
        if (p > 0) gap = i - last;
        last = i;
        p++;
      end
      if (bus.rsp_valid) begin
        nrsp++;
        vectors++;
        if (bus.rsp_rdata !== 32'h12347F80) begin
          miscompares++;
          $display("FAIL b2b_data got %h expected 12347f80", bus.rsp_rdata);
        end
      end
    end
    vectors++;
    if (p != 2 || nrsp != 2 || gap < 3) begin
      miscompares++;
      $display("FAIL b2b_pulses got pulses=%0d responses=%0d gap=%0d expected 2 2 >=3", p, nrsp, gap);
    end
  endtask
  task automatic test_reset_mid;
    int n;
    n = 0;
    send(1'b0, 32'h10, 32'd0, MEM_WORD, 5'd6);
    tick;
    rst_n = 1'b0;
    tick;
    vectors++;
    if ({bus.req_ready, bus.mem_start, bus.rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_mid got req_ready=%b start=%b rsp_valid=%b expected 1 0 0", bus.req_ready,
               bus.mem_start, bus.rsp_valid);
    end
    rst_n = 1'b1;
    repeat (8) begin
      tick;
      if (bus.rsp_valid) n++;
    end
    vectors++;
    if (n != 0 || bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_quiet got rsp_valid cycles=%0d req_ready=%b expected 0 1", n, bus.req_ready);
    end
    test_load(32'h10, MEM_BYTE, 32'hFFFFFF80, 5'd11);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_size = MEM_WORD;
    bus.req_rd = 5'd0;
    bus.rsp_ready = 1'b1;
    test_reset;
    test_load(32'h10, MEM_BYTE, 32'hFFFFFF80, 5'd1);
    test_load(32'h10, MEM_BU, 32'h00000080, 5'd2);
    test_load(32'h12, MEM_HALF, 32'h00001234, 5'd3);
    test_load(32'h10, MEM_WORD, 32'h12347F80, 5'd4);
    test_load(32'h11, MEM_BYTE, 32'h0000007F, 5'd5);
    test_load(32'h10, MEM_HU, 32'h00007F80, 5'd6);
    test_stores;
    test_errors;
    test_timeout;
    test_load(32'h12, MEM_HU, 32'h00001234, 5'd12);
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
